// File: rtl/spm_seq_mult.sv
// Serial-parallel multiplier: a chain of carry-save cells consumes one multiplier bit per
// cycle, streams the product LSB-first and then presents it in parallel under a start/ready handshake.
module spm_seq_mult #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode_signed,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 ready,
    output logic                 busy,
    output logic                 pbit,
    output logic                 pbit_valid,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int N  = SIGNED_EN ? 2 * WIDTH : WIDTH;
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(PW);
    localparam logic [CW-1:0] CNT_LAST = CW'(PW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      xe_q, xe_d;
    logic [WIDTH-1:0]  ysh_q, ysh_d;
    logic              mode_q, mode_d;
    logic [N-1:0]      sum_q, sum_d;
    logic [N-1:0]      sc_q, sc_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic [PW-1:0]     p_q, p_d;
    logic              pbit_q, pbit_d;
    logic              pbit_valid_q, pbit_valid_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic              accept_s;
    logic              mode_eff_s;
    logic [N-1:0]      xe_ext_s;
    logic [N-1:0]      addend_s;
    logic [N-1:0]      sum_in_s;
    logic [N-1:0]      csa_sum_s;
    logic [N-1:0]      csa_carry_s;
    logic [WIDTH-1:0]  ysh_shift_s;

    assign accept_s = start && (state_q != ST_RUN);

    // Datapath: operand extension, multiplier-bit serialiser and the carry-save cell chain
    always_comb begin
        mode_eff_s = mode_signed & SIGNED_EN;
        xe_ext_s = {N{mode_eff_s & x[WIDTH-1]}};
        xe_ext_s[WIDTH-1:0] = x;
        // Arithmetic right shift in signed mode keeps supplying y's sign bit once y is exhausted.
        ysh_shift_s = ysh_q >> 1'b1;
        ysh_shift_s[WIDTH-1] = mode_q & ysh_q[WIDTH-1];
        addend_s = xe_q & {N{ysh_q[0]}};
        sum_in_s = sum_q >> 1'b1;
        csa_sum_s = addend_s ^ sum_in_s ^ sc_q;
        csa_carry_s = (addend_s & sum_in_s) | (addend_s & sc_q) | (sum_in_s & sc_q);
    end

    // Controller next-state and register next values
    always_comb begin
        state_d      = state_q;
        cnt_d        = accept_s ? {CW{1'b0}} : cnt_q;
        xe_d         = accept_s ? xe_ext_s : xe_q;
        ysh_d        = accept_s ? y : ysh_q;
        mode_d       = accept_s ? mode_eff_s : mode_q;
        sum_d        = accept_s ? {N{1'b0}} : sum_q;
        sc_d         = accept_s ? {N{1'b0}} : sc_q;
        prod_d       = accept_s ? {PW{1'b0}} : prod_q;
        p_d          = p_q;
        pbit_d       = 1'b0;
        pbit_valid_d = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = accept_s ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                sum_d        = csa_sum_s;
                sc_d         = csa_carry_s;
                ysh_d        = ysh_shift_s;
                pbit_d       = csa_sum_s[0];
                pbit_valid_d = 1'b1;
                prod_d       = {csa_sum_s[0], prod_q[PW-1:1]};
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                // The parallel result and done pulse land on the edge leaving DONE, so a
                // start accepted here overlaps with them and the next run has no gap.
                done_d  = 1'b1;
                p_d     = prod_q;
                state_d = accept_s ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d != ST_RUN);
        busy_d  = (state_d == ST_RUN);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CW{1'b0}};
            xe_q         <= {N{1'b0}};
            ysh_q        <= {WIDTH{1'b0}};
            mode_q       <= 1'b0;
            sum_q        <= {N{1'b0}};
            sc_q         <= {N{1'b0}};
            prod_q       <= {PW{1'b0}};
            p_q          <= {PW{1'b0}};
            pbit_q       <= 1'b0;
            pbit_valid_q <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            xe_q         <= xe_d;
            ysh_q        <= ysh_d;
            mode_q       <= mode_d;
            sum_q        <= sum_d;
            sc_q         <= sc_d;
            prod_q       <= prod_d;
            p_q          <= p_d;
            pbit_q       <= pbit_d;
            pbit_valid_q <= pbit_valid_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    assign ready      = ready_q;
    assign busy       = busy_q;
    assign pbit       = pbit_q;
    assign pbit_valid = pbit_valid_q;
    assign done       = done_q;
    assign p          = p_q;

endmodule

// File: tb/tb_spm_seq_mult.sv
// Bench for spm_seq_mult: an arithmetic protocol model checked every cycle, plus directed
// vectors with hand-computed products, stream, latency and reset expectations.
module tb_spm_seq_mult;

    localparam int W   = 8;
    localparam int PW  = 2 * W;
    localparam int LAT = PW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode_signed = 1'b0;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic          ready, busy, pbit, pbit_valid, done;
    logic [PW-1:0] p;

    logic          start1 = 1'b0;
    logic          mode1 = 1'b0;
    logic [0:0]    x1 = '0;
    logic [0:0]    y1 = '0;
    logic          ready1, busy1, pbit1, pbit_valid1, done1;
    logic [1:0]    p1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spm_seq_mult #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode_signed(mode_signed), .x(x), .y(y),
        .ready(ready), .busy(busy), .pbit(pbit), .pbit_valid(pbit_valid), .done(done), .p(p)
    );

    spm_seq_mult #(.WIDTH(1), .SIGNED_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode_signed(mode1), .x(x1), .y(y1),
        .ready(ready1), .busy(busy1), .pbit(pbit1), .pbit_valid(pbit_valid1), .done(done1), .p(p1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic sgn);
        longint sa;
        longint sb;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[W-1]) sa = sa - (longint'(1) << W);
        if (sgn && b[W-1]) sb = sb - (longint'(1) << W);
        return PW'(sa * sb);
    endfunction

    // Protocol model: m_cnt counts product bits emitted since the accepting edge.
    logic          m_active = 1'b0;
    int            m_cnt = 0;
    logic [PW-1:0] m_prod = '0;
    logic          exp_pbit = 1'b0;
    logic          exp_pbit_valid = 1'b0;
    logic          exp_done = 1'b0;
    logic [PW-1:0] exp_p = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active       <= 1'b0;
            m_cnt          <= 0;
            m_prod         <= '0;
            exp_pbit       <= 1'b0;
            exp_pbit_valid <= 1'b0;
            exp_done       <= 1'b0;
            exp_p          <= '0;
        end else begin
            exp_pbit       <= 1'b0;
            exp_pbit_valid <= 1'b0;
            exp_done       <= 1'b0;
            if (m_active && m_cnt < PW) begin
                exp_pbit       <= m_prod[m_cnt];
                exp_pbit_valid <= 1'b1;
                m_cnt          <= m_cnt + 1;
            end else if (m_active) begin
                exp_done <= 1'b1;
                exp_p    <= m_prod;
                if (start) begin
                    m_prod <= model_prod(x, y, mode_signed);
                    m_cnt  <= 0;
                end else begin
                    m_active <= 1'b0;
                end
            end else if (start) begin
                m_prod   <= model_prod(x, y, mode_signed);
                m_cnt    <= 0;
                m_active <= 1'b1;
            end
        end
    end

    always begin
        @(posedge clk);
        #3;
        if (!rst) begin
            check("cyc_ready", 64'(ready), 64'(!m_active || m_cnt == PW));
            check("cyc_busy", 64'(busy), 64'(m_active && m_cnt < PW));
            check("cyc_pbit_valid", 64'(pbit_valid), 64'(exp_pbit_valid));
            check("cyc_done", 64'(done), 64'(exp_done));
            check("cyc_p", 64'(p), 64'(exp_p));
            if (exp_pbit_valid) check("cyc_pbit", 64'(pbit), 64'(exp_pbit));
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(ready), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_pbit"}, 64'(pbit), 64'(0));
        check({tag, "_pbit_valid"}, 64'(pbit_valid), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_p"}, 64'(p), 64'(0));
    endtask

    // One operation; intrude>0 pulses start with other operands at that RUN cycle.
    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] ya,
                          input logic ma, input int intrude,
                          output logic [PW-1:0] p_got, output logic [PW-1:0] stream);
        int idx;
        int lat;
        idx = 0;
        lat = -1;
        p_got = '0;
        stream = '0;
        @(negedge clk);
        start = 1'b1; x = xa; y = ya; mode_signed = ma;
        @(posedge clk);
        #3;
        start = 1'b0; x = ~xa; y = ~ya;
        for (int n = 1; n <= 40; n++) begin
            if (n == intrude) begin
                start = 1'b1; x = 8'h55; y = 8'hAA; mode_signed = ~ma;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #3;
            if (pbit_valid) begin
                if (idx < PW) stream[idx] = pbit;
                idx++;
            end
            if (done) begin
                lat = n;
                p_got = p;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_nbits"}, 64'(idx), 64'(PW));
    endtask

    initial begin
        logic [PW-1:0] pg;
        logic [PW-1:0] st;
        int d1;
        int d2;
        int dn;
        int lat1;
        logic [1:0] st1;
        int idx1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");
        check("reset_ready1", 64'(ready1), 64'(1));
        check("reset_p1", 64'(p1), 64'(0));

        run_op("t1", 8'hFF, 8'hFF, 1'b0, 0, pg, st);
        check("t1_p", 64'(pg), 64'(16'hFE01));
        check("t1_stream", 64'(st), 64'(16'hFE01));

        run_op("t2s", 8'h80, 8'h7F, 1'b1, 0, pg, st);
        check("t2s_p", 64'(pg), 64'(16'hC080));
        check("t2s_stream", 64'(st), 64'(16'hC080));
        run_op("t2u", 8'h80, 8'h7F, 1'b0, 0, pg, st);
        check("t2u_p", 64'(pg), 64'(16'h3F80));

        run_op("t3a", 8'hFF, 8'hFF, 1'b1, 0, pg, st);
        check("t3a_p", 64'(pg), 64'(16'h0001));
        run_op("t3b", 8'h00, 8'h80, 1'b1, 0, pg, st);
        check("t3b_p", 64'(pg), 64'(16'h0000));

        run_op("t4", 8'h12, 8'h34, 1'b0, 5, pg, st);
        check("t4_p", 64'(pg), 64'(16'h03A8));
        dn = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #3;
            if (done) dn++;
        end
        check("t4_extra_done", 64'(dn), 64'(0));
        check("t4_p_held", 64'(p), 64'(16'h03A8));

        // Reset asserted between edges during RUN cycle 5.
        @(negedge clk);
        start = 1'b1; x = 8'hFF; y = 8'hFF; mode_signed = 1'b0;
        @(posedge clk);
        #3;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #3;
        end
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #3;
            if (done) dn++;
        end
        check("t5_no_done", 64'(dn), 64'(0));
        run_op("t5_after", 8'd3, 8'd5, 1'b0, 0, pg, st);
        check("t5_after_p", 64'(pg), 64'(16'd15));

        // Back-to-back: start held high until the second operation has been accepted.
        @(negedge clk);
        start = 1'b1; x = 8'd3; y = 8'd5; mode_signed = 1'b0;
        @(posedge clk);
        #3;
        x = 8'd7; y = 8'd9;
        d1 = -1;
        d2 = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #3;
            if (done && d1 < 0) begin
                d1 = n;
                start = 1'b0;
                check("t6_p_first", 64'(p), 64'(16'd15));
            end else if (done) begin
                d2 = n;
                check("t6_p_second", 64'(p), 64'(16'd63));
                break;
            end
        end
        start = 1'b0;
        check("t6_first_latency", 64'(d1), 64'(LAT));
        check("t6_spacing", 64'(d2 - d1), 64'(LAT));

        // WIDTH=1 instance: signed -1 * -1 streams 1,0 and yields 2'b01 after 3 cycles.
        @(negedge clk);
        start1 = 1'b1; x1 = 1'b1; y1 = 1'b1; mode1 = 1'b1;
        @(posedge clk);
        #3;
        start1 = 1'b0; x1 = 1'b0; y1 = 1'b0;
        check("w1_busy", 64'(busy1), 64'(1));
        lat1 = -1;
        idx1 = 0;
        st1 = 2'b11;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #3;
            if (pbit_valid1) begin
                if (idx1 < 2) st1[idx1] = pbit1;
                idx1++;
            end
            if (done1) begin
                lat1 = n;
                check("w1_p", 64'(p1), 64'(2'b01));
                break;
            end
        end
        check("w1_latency", 64'(lat1), 64'(3));
        check("w1_stream", 64'(st1), 64'(2'b01));
        check("w1_nbits", 64'(idx1), 64'(2));

        repeat (3) @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, reached %0t", $time);
        $fatal(1);
    end

endmodule
